// File: rtl/toy_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : toy_loader_pkg
//  Description : Shared types and constants for the toy loader arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package toy_loader_pkg;

    // Data width of the stupid_toy_loader that sits behind the arbiter
    localparam int LOADER_DATA_W = 8;

    // Arbiter / burst sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Width of an index into NUM_REQ requesters (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : toy_loader_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin finder. Returns the first set
//                request bit at or above ptr, wrapping past NUM_REQ-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import toy_loader_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    // One extra bit so ptr + offset never overflows before the wrap
    localparam int CW = IDX_W + 1;

    logic [CW-1:0] cand;

    // Walk offsets 0..NUM_REQ-1 from ptr; the first hit wins
    always_comb begin
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid                  = 1'b1;
                index                  = cand[IDX_W-1:0];
                winner[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/toy_loader_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : toy_loader_arbiter
//  Description : Round-robin arbiter and burst sequencer sharing one
//                stupid_toy_loader between NUM_REQ requesters. A granted
//                requester streams req_len beats, one per cycle, followed by
//                a single idle gap cycle before the next arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module toy_loader_arbiter
    import toy_loader_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = LOADER_DATA_W,
    parameter int LEN_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         load_data,
    output logic                      load_enable,
    output logic                      busy,
    output logic                      abort
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    ptr_nxt;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    owner_nxt;
    logic [LEN_W-1:0]    beats_left;
    logic [LEN_W-1:0]    beats_nxt;
    logic [NUM_REQ-1:0]  grant_nxt;
    logic [DATA_W-1:0]   load_data_nxt;
    logic                load_enable_nxt;
    logic                busy_nxt;
    logic                abort_nxt;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [LEN_W-1:0]    pick_len;
    logic                owner_req;
    logic [DATA_W-1:0]   owner_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_onehot),
        .index  (pick_idx),
        .valid  (pick_valid)
    );

    // Fields of the arbitration winner and of the current owner
    assign pick_len   = req_len[int'(pick_idx) * LEN_W +: LEN_W];
    assign owner_req  = req[owner];
    assign owner_data = req_data[int'(owner) * DATA_W +: DATA_W];

    // Owner's beat is consumed at the next edge whenever it still requests
    assign ack = (state == LOAD) ? (grant & req) : '0;

    // Next-state and next-output logic for the sequencer
    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        owner_nxt       = owner;
        beats_nxt       = beats_left;
        grant_nxt       = grant;
        load_data_nxt   = load_data;
        load_enable_nxt = 1'b0;
        busy_nxt        = busy;
        abort_nxt       = 1'b0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_nxt = pick_onehot;
                    owner_nxt = pick_idx;
                    // A zero length still moves one beat
                    beats_nxt = (pick_len == '0) ? LEN_W'(1) : pick_len;
                    busy_nxt  = 1'b1;
                    state_nxt = LOAD;
                end
            end

            LOAD: begin
                if (owner_req) begin
                    load_data_nxt   = owner_data;
                    load_enable_nxt = 1'b1;
                    beats_nxt       = beats_left - LEN_W'(1);
                    if (beats_left == LEN_W'(1)) begin
                        state_nxt = GAP;
                    end
                end else begin
                    // Owner withdrew mid-burst: drop the remaining beats
                    abort_nxt = 1'b1;
                    state_nxt = GAP;
                end
            end

            GAP: begin
                grant_nxt = '0;
                busy_nxt  = 1'b0;
                beats_nxt = '0;
                ptr_nxt   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
                state_nxt = IDLE;
            end

            default: begin
                grant_nxt = '0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            beats_left  <= '0;
            grant       <= '0;
            load_data   <= '0;
            load_enable <= 1'b0;
            busy        <= 1'b0;
            abort       <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            owner       <= owner_nxt;
            beats_left  <= beats_nxt;
            grant       <= grant_nxt;
            load_data   <= load_data_nxt;
            load_enable <= load_enable_nxt;
            busy        <= busy_nxt;
            abort       <= abort_nxt;
        end
    end

endmodule : toy_loader_arbiter
`default_nettype wire

// File: tb/tb_toy_loader_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_toy_loader_arbiter
//  Description : Self-checking bench for toy_loader_arbiter. Expected loader
//                beats are queued when a burst is driven and popped when the
//                loader sees load_enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_toy_loader_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [11:0] req_len;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [7:0]  load_data;
    logic        load_enable;
    logic        busy;
    logic        abort;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q [$];
    int         beats_total = 0;
    int         abort_total = 0;
    int         busy_total  = 0;
    int         beat_cyc [256];
    logic [7:0] beat_val [256];
    logic [7:0] bts [8];
    logic [7:0] ref_vals [3];

    always #5 clk = ~clk;

    toy_loader_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8),
        .LEN_W   (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .req_len     (req_len),
        .ack         (ack),
        .grant       (grant),
        .load_data   (load_data),
        .load_enable (load_enable),
        .busy        (busy),
        .abort       (abort)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Loader model and scoreboard: every enabled cycle is one loaded beat
    always @(negedge clk) begin : mon
        automatic logic [31:0] want;
        if (load_enable) begin
            if (exp_q.size() != 0) want = {24'd0, exp_q.pop_front()};
            else                   want = 32'h100;
            check("sb_beat", {24'd0, load_data}, want);
            beat_cyc[beats_total % 256] <= cyc;
            beat_val[beats_total % 256] <= load_data;
            beats_total <= beats_total + 1;
        end
        if (abort) abort_total <= abort_total + 1;
        if (busy)  busy_total  <= busy_total + 1;
    end

    // mode 0: blocking, 1: nonblocking, 2: blocking 0.5 ns before the edge
    task automatic apply(input int i, input logic r, input logic [7:0] d, input int len, input int mode);
        if (mode == 1) begin
            req[i]             <= r;
            req_data[i*8 +: 8] <= d;
            req_len[i*3 +: 3]  <= 3'(len);
        end else begin
            req[i]             = r;
            req_data[i*8 +: 8] = d;
            req_len[i*3 +: 3]  = 3'(len);
        end
    endtask

    // Requester i: present beats, advance after each acked edge, drop req after n_send
    task automatic drive_burst(input int i, input int len, input int n_send, input int mode,
                               input logic [7:0] beats [8], output int req_cyc);
        int   k;
        int   guard;
        logic a;
        k = 0;
        guard = 0;
        @(posedge clk);
        if (mode == 2) #9.5; else #1;
        apply(i, 1'b1, beats[0], len, mode);
        req_cyc = cyc;
        while (k < n_send && guard < 50) begin
            if (mode == 2) #0.1;
            else begin
                @(negedge clk);
                #4.6;
            end
            a = ack[i];
            @(posedge clk);
            guard++;
            if (a) k++;
            if (mode == 2) #9.5; else #1;
            if (k >= n_send) apply(i, 1'b0, beats[0], len, mode);
            else             apply(i, 1'b1, beats[k], len, mode);
        end
        if (k < n_send) check("burst_timeout", k, n_send);
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check({tag, "_idle"}, busy, 0);
    endtask

    // All four request with len=1; expect n grants starting at 'first'
    task automatic rr_all(input int n, input int first, input string tag);
        int prev;
        int idx;
        int guard;
        prev = 0;
        for (int i = 0; i < 4; i++) apply(i, 1'b1, 8'(16 + i), 1, 0);
        for (int j = 0; j < n; j++) exp_q.push_back(8'(16 + (first + j) % 4));
        for (int j = 0; j < n; j++) begin
            guard = 0;
            @(negedge clk);
            while (!load_enable && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (j == n - 1) req = '0;
            idx = (first + j) % 4;
            check({tag, "_beat_seen"}, load_enable, 1);
            check({tag, "_grant"}, grant, 32'(1 << idx));
            if (j > 0) check({tag, "_spacing"}, cyc - prev, 3);
            prev = cyc;
            @(negedge clk);
            check({tag, "_width"}, load_enable, 0);
        end
        wait_idle(tag);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int a0;
        int z0;
        int rc;

        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        req_len  = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #3;
        check("rst_grant", grant, 0);
        check("rst_le", load_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_abort", abort, 0);
        check("rst_data", load_data, 0);
        check("rst_ack", ack, 0);
        @(negedge clk);
        reset = 1'b1;

        // ---------------- single burst ----------------
        b0 = beats_total; a0 = abort_total; z0 = busy_total;
        bts = '{8'h3a, 8'h3b, 8'hff, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q.push_back(8'h3a); exp_q.push_back(8'h3b); exp_q.push_back(8'hff);
        fork
            drive_burst(0, 3, 3, 0, bts, rc);
            begin
                @(posedge clk);
                @(negedge clk);
                check("single_ack_idle", ack, 0);
                check("single_grant_idle", grant, 0);
                @(negedge clk);
                check("single_grant", grant, 4'b0001);
                check("single_ack", ack, 4'b0001);
                check("single_busy", busy, 1);
            end
        join
        wait_idle("single");
        check("single_beats", beats_total - b0, 3);
        check("single_latency", beat_cyc[b0 % 256] - rc, 2);
        check("single_contig", beat_cyc[(b0 + 2) % 256] - beat_cyc[b0 % 256], 2);
        check("single_busy_cycles", busy_total - z0, 4);
        check("single_no_abort", abort_total - a0, 0);
        check("single_grant_end", grant, 0);
        check("single_hold", load_data, 8'hff);
        check("single_le_end", load_enable, 0);

        // ---------------- reset mid-burst ----------------
        b0 = beats_total;
        exp_q.push_back(8'h3a); exp_q.push_back(8'h3a);
        @(posedge clk);
        #1;
        apply(1, 1'b1, 8'h3a, 5, 0);
        repeat (3) @(posedge clk);
        #7;
        reset = 1'b0;
        #1;
        check("arst_le", load_enable, 0);
        check("arst_grant", grant, 0);
        check("arst_busy", busy, 0);
        check("arst_ack", ack, 0);
        check("arst_data", load_data, 0);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_beats", beats_total - b0, 2);
        check("arst_drained", exp_q.size(), 0);

        // ---------------- round robin from ptr 0 ----------------
        rr_all(5, 0, "rr");

        // ---------------- abort ----------------
        b0 = beats_total; a0 = abort_total;
        bts = '{8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q.push_back(8'ha0); exp_q.push_back(8'ha1);
        drive_burst(2, 4, 2, 0, bts, rc);
        wait_idle("abort");
        check("abort_beats", beats_total - b0, 2);
        check("abort_pulse", abort_total - a0, 1);
        check("abort_drained", exp_q.size(), 0);
        rr_all(1, 3, "ptr_after_abort");

        // ---------------- len=0 ----------------
        b0 = beats_total;
        bts = '{8'h55, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q.push_back(8'h55);
        drive_burst(1, 0, 1, 0, bts, rc);
        repeat (3) @(negedge clk);
        wait_idle("len0");
        check("len0_beats", beats_total - b0, 1);

        // ---------------- len=7 ----------------
        b0 = beats_total;
        for (int j = 0; j < 8; j++) bts[j] = 8'(8'h70 + j);
        for (int j = 0; j < 7; j++) exp_q.push_back(8'(8'h70 + j));
        drive_burst(3, 7, 7, 0, bts, rc);
        wait_idle("len7");
        check("len7_beats", beats_total - b0, 7);
        check("len7_contig", beat_cyc[(b0 + 6) % 256] - beat_cyc[b0 % 256], 6);

        // ---------------- stimulus timing mix ----------------
        bts = '{8'hc1, 8'hc2, 8'hc3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int m = 0; m < 3; m++) begin
            b0 = beats_total;
            exp_q.push_back(8'hc1); exp_q.push_back(8'hc2); exp_q.push_back(8'hc3);
            drive_burst(0, 3, 3, m, bts, rc);
            wait_idle("mix");
            check("mix_beats", beats_total - b0, 3);
            check("mix_latency", beat_cyc[b0 % 256] - rc, 2);
            for (int j = 0; j < 3; j++) begin
                if (m == 0) ref_vals[j] = beat_val[(b0 + j) % 256];
                else        check("mix_same", beat_val[(b0 + j) % 256], ref_vals[j]);
            end
        end
        check("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_toy_loader_arbiter
`default_nettype wire
